// File: rtl/move_order_pkg.sv
// move_order_pkg: shared types and constants for the move ordering buffer.
// Default entry widths match the evaluate block (24-bit eval, 16-bit UCI move).
package move_order_pkg;

    localparam int EVAL_W = 24;
    localparam int UCI_W  = 16;
    localparam int KEY_W  = EVAL_W + 1;

    // Largest positive sort key; a PV entry is pinned to this value.
    localparam logic signed [KEY_W-1:0] KEY_MAX = {1'b0, {(KEY_W-1){1'b1}}};

    typedef struct packed {
        logic signed [EVAL_W-1:0] eval;
        logic [UCI_W-1:0]         uci;
        logic                     pv;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        READ = 2'd2
    } state_t;

endpackage

// File: rtl/move_order_key.sv
// move_order_key: maps (eval, pv, side-to-move) to a signed sort key where a
// larger key means "better for the side to move". One extra bit keeps the
// negation of the most negative eval representable.
// Optional feature macro: MOVE_ORDER_PV_EN (PV entries take the maximum key).
module move_order_key
    import move_order_pkg::*;
#(
    parameter int EVAL_WIDTH = EVAL_W
) (
    input  logic signed [EVAL_WIDTH-1:0] eval,
    input  logic                         pv,
    input  logic                         sense,
    output logic signed [EVAL_WIDTH:0]   key
);

    logic signed [EVAL_WIDTH:0] eval_x;
    logic signed [EVAL_WIDTH:0] base_key;

    assign eval_x = {eval[EVAL_WIDTH-1], eval};

    // White keeps the score as is; black sorts on the negated score.
    always_comb begin
        base_key = sense ? eval_x : -eval_x;
    end

`ifdef MOVE_ORDER_PV_EN
    // A PV entry outranks every ordinary score.
    always_comb begin
        key = pv ? {1'b0, {EVAL_WIDTH{1'b1}}} : base_key;
    end
`else
    logic unused_pv;
    assign unused_pv = pv;

    // PV flag has no effect in this build.
    always_comb begin
        key = base_key;
    end
`endif

endmodule

// File: rtl/move_order_buf.sv
// move_order_buf: collects scored child moves of one parent node, keeps them
// sorted best-first for the side to move (stable, ties in arrival order) and
// then hands them out one per rd_req.
// Optional feature macro: MOVE_ORDER_PV_EN (PV move jumps to the list head).
module move_order_buf
    import move_order_pkg::*;
#(
    parameter int  EVAL_WIDTH = EVAL_W,
    parameter int  UCI_WIDTH  = UCI_W,
    parameter int  MAX_MOVES  = 64,
    localparam int CNT_W      = $clog2(MAX_MOVES) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         white_to_move,
    input  logic                         eval_valid,
    input  logic signed [EVAL_WIDTH-1:0] eval,
    input  logic                         eval_pv_flag,
    input  logic [UCI_WIDTH-1:0]         uci_in,
    input  logic                         fill_done,
    input  logic                         rd_req,
    output logic                         rd_valid,
    output logic signed [EVAL_WIDTH-1:0] rd_eval,
    output logic [UCI_WIDTH-1:0]         rd_uci,
    output logic                         rd_empty,
    output logic [CNT_W-1:0]             count,
    output logic                         overflow,
    output logic                         protocol_err
);

    state_t                      state_q, state_d;
    logic                        sense_q, sense_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [CNT_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic                        overflow_q, overflow_d;
    logic                        perr_q, perr_d;
    logic                        rd_valid_q, rd_valid_d;
    logic signed [EVAL_WIDTH-1:0] rd_eval_q, rd_eval_d;
    logic [UCI_WIDTH-1:0]        rd_uci_q, rd_uci_d;

    logic signed [EVAL_WIDTH-1:0] ent_eval_q [MAX_MOVES];
    logic signed [EVAL_WIDTH-1:0] ent_eval_d [MAX_MOVES];
    logic [UCI_WIDTH-1:0]        ent_uci_q  [MAX_MOVES];
    logic [UCI_WIDTH-1:0]        ent_uci_d  [MAX_MOVES];
    logic                        ent_pv_q   [MAX_MOVES];
    logic                        ent_pv_d   [MAX_MOVES];

    logic signed [EVAL_WIDTH:0]  new_key;
    logic signed [EVAL_WIDTH:0]  ent_key [MAX_MOVES];
    logic [MAX_MOVES-1:0]        ahead;
    logic [CNT_W-1:0]            ins_pos;
    logic                        pv_first;

`ifdef MOVE_ORDER_PV_EN
    assign pv_first = eval_pv_flag;
`else
    assign pv_first = 1'b0;
`endif

    move_order_key #(.EVAL_WIDTH(EVAL_WIDTH)) u_key_in (
        .eval  (eval),
        .pv    (eval_pv_flag),
        .sense (sense_q),
        .key   (new_key)
    );

    for (genvar g = 0; g < MAX_MOVES; g++) begin : g_ent_key
        move_order_key #(.EVAL_WIDTH(EVAL_WIDTH)) u_key (
            .eval  (ent_eval_q[g]),
            .pv    (ent_pv_q[g]),
            .sense (sense_q),
            .key   (ent_key[g])
        );
    end

    // The list is sorted, so entries staying ahead of the new one form a
    // prefix and their population count is the insertion slot. A new PV
    // entry must beat earlier PV entries of equal key, hence the override.
    always_comb begin
        ahead   = '0;
        ins_pos = '0;
        for (int unsigned i = 0; i < MAX_MOVES; i++) begin
            ahead[i] = (CNT_W'(i) < count_q) && (ent_key[i] >= new_key) && !pv_first;
            ins_pos  = ins_pos + CNT_W'(ahead[i]);
        end
    end

    // FSM next state, insertion shifter, read pointer and sticky flags.
    always_comb begin
        state_d    = state_q;
        sense_d    = sense_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        perr_d     = perr_q;
        rd_valid_d = 1'b0;
        rd_eval_d  = rd_eval_q;
        rd_uci_d   = rd_uci_q;
        ent_eval_d = ent_eval_q;
        ent_uci_d  = ent_uci_q;
        ent_pv_d   = ent_pv_q;

        if (clear) begin
            state_d    = FILL;
            sense_d    = white_to_move;
            count_d    = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
            perr_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (eval_valid || rd_req) perr_d = 1'b1;
                end
                FILL: begin
                    if (rd_req) perr_d = 1'b1;
                    if (eval_valid) begin
                        if (count_q == CNT_W'(MAX_MOVES)) overflow_d = 1'b1;
                        else                              count_d    = count_q + CNT_W'(1);
                        // On a full list a slot past the tail means the new entry loses.
                        if (ins_pos < CNT_W'(MAX_MOVES)) begin
                            for (int unsigned i = 1; i < MAX_MOVES; i++) begin
                                if (CNT_W'(i) > ins_pos) begin
                                    ent_eval_d[i] = ent_eval_q[i-1];
                                    ent_uci_d[i]  = ent_uci_q[i-1];
                                    ent_pv_d[i]   = ent_pv_q[i-1];
                                end
                            end
                            for (int unsigned i = 0; i < MAX_MOVES; i++) begin
                                if (CNT_W'(i) == ins_pos) begin
                                    ent_eval_d[i] = eval;
                                    ent_uci_d[i]  = uci_in;
                                    ent_pv_d[i]   = eval_pv_flag;
                                end
                            end
                        end
                    end
                    if (fill_done) state_d = READ;
                end
                READ: begin
                    if (eval_valid) perr_d = 1'b1;
                    if (rd_req && (rd_ptr_q < count_q)) begin
                        rd_valid_d = 1'b1;
                        rd_eval_d  = ent_eval_q[rd_ptr_q[CNT_W-2:0]];
                        rd_uci_d   = ent_uci_q[rd_ptr_q[CNT_W-2:0]];
                        rd_ptr_d   = rd_ptr_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control and output registers; reset returns to IDLE immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sense_q    <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            perr_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_eval_q  <= '0;
            rd_uci_q   <= '0;
        end else begin
            state_q    <= state_d;
            sense_q    <= sense_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            perr_q     <= perr_d;
            rd_valid_q <= rd_valid_d;
            rd_eval_q  <= rd_eval_d;
            rd_uci_q   <= rd_uci_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        ent_eval_q <= ent_eval_d;
        ent_uci_q  <= ent_uci_d;
        ent_pv_q   <= ent_pv_d;
    end

    assign rd_valid     = rd_valid_q;
    assign rd_eval      = rd_eval_q;
    assign rd_uci       = rd_uci_q;
    assign rd_empty     = (state_q == READ) && (rd_ptr_q == count_q);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_move_order_buf.sv
// tb_move_order_buf: directed and randomized stimulus against a queue-based
// reference list; popped entries are checked by an independent monitor.
// Honours MOVE_ORDER_PV_EN when defined for the build.
module tb_move_order_buf;
    import move_order_pkg::*;

    localparam int MAXM  = 8;
    localparam int CNT_W = $clog2(MAXM) + 1;
`ifdef MOVE_ORDER_PV_EN
    localparam bit PV_EN = 1'b1;
`else
    localparam bit PV_EN = 1'b0;
`endif

    logic                     clk, reset, clear, white_to_move, eval_valid;
    logic signed [EVAL_W-1:0] eval;
    logic                     eval_pv_flag, fill_done, rd_req;
    logic [UCI_W-1:0]         uci_in;
    logic                     rd_valid, rd_empty, overflow, protocol_err;
    logic signed [EVAL_W-1:0] rd_eval;
    logic [UCI_W-1:0]         rd_uci;
    logic [CNT_W-1:0]         count;

    move_order_buf #(.EVAL_WIDTH(EVAL_W), .UCI_WIDTH(UCI_W), .MAX_MOVES(MAXM)) dut (
        .clk(clk), .reset(reset), .clear(clear), .white_to_move(white_to_move),
        .eval_valid(eval_valid), .eval(eval), .eval_pv_flag(eval_pv_flag),
        .uci_in(uci_in), .fill_done(fill_done), .rd_req(rd_req),
        .rd_valid(rd_valid), .rd_eval(rd_eval), .rd_uci(rd_uci),
        .rd_empty(rd_empty), .count(count), .overflow(overflow),
        .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    entry_t exp_q[$];
    entry_t mlist[$];
    state_t mstate;
    bit     msense, mov, mperr;
    int     mrd;
    entry_t mon_e;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint mkey(entry_t e);
        longint v;
        v = longint'(e.eval);
        if (PV_EN && e.pv) return 64'sd1 <<< 40;
        return msense ? v : -v;
    endfunction

    // Reference: walk the list past every entry that ranks at least as well.
    task automatic model_insert(entry_t e);
        int     pos;
        longint nk;
        nk  = mkey(e);
        pos = 0;
        if (!(PV_EN && e.pv))
            while (pos < mlist.size() && mkey(mlist[pos]) >= nk) pos++;
        if (mlist.size() < MAXM) begin
            mlist.insert(pos, e);
        end else begin
            mov = 1'b1;
            if (pos < MAXM) begin
                mlist.insert(pos, e);
                void'(mlist.pop_back());
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input bit wtm, input bit with_eval);
        clear = 1'b1; white_to_move = wtm; eval_valid = with_eval;
        eval = EVAL_W'(7); uci_in = 16'hBEEF;
        tick();
        clear = 1'b0; eval_valid = 1'b0;
        mlist.delete(); mrd = 0; mov = 1'b0; mperr = 1'b0; msense = wtm; mstate = FILL;
    endtask

    task automatic do_push(input int ev, input int uci, input bit pv, input bit done);
        entry_t e;
        e.eval = EVAL_W'(ev); e.uci = UCI_W'(uci); e.pv = pv;
        eval_valid = 1'b1; eval = e.eval; uci_in = e.uci; eval_pv_flag = pv; fill_done = done;
        tick();
        eval_valid = 1'b0; eval_pv_flag = 1'b0; fill_done = 1'b0;
        if (mstate == FILL) begin
            model_insert(e);
            if (done) mstate = READ;
        end else begin
            mperr = 1'b1;
        end
    endtask

    task automatic do_done();
        fill_done = 1'b1;
        tick();
        fill_done = 1'b0;
        if (mstate == FILL) mstate = READ;
    endtask

    task automatic do_pop();
        if (mstate == READ) begin
            if (mrd < mlist.size()) begin
                exp_q.push_back(mlist[mrd]);
                mrd++;
            end
        end else begin
            mperr = 1'b1;
        end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"}, count, mlist.size());
        check({tag, ".overflow"}, overflow, mov);
        check({tag, ".protocol_err"}, protocol_err, mperr);
        check({tag, ".rd_empty"}, rd_empty, (mstate == READ) && (mrd == mlist.size()));
    endtask

    // Bounded wait for every expected pop to be seen by the monitor.
    task automatic drain(input string tag);
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) tick();
        check({tag, ".pending_pops"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic pop_all(input string tag);
        int n;
        n = mlist.size();
        for (int k = 0; k < n; k++) do_pop();
        drain(tag);
        check_status(tag);
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset && rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_valid: got rd_valid=1 expected no output");
            end else begin
                mon_e = exp_q.pop_front();
                check("rd_eval", rd_eval, mon_e.eval);
                check("rd_uci", rd_uci, mon_e.uci);
            end
        end
    end

    initial begin
        logic signed [EVAL_W-1:0] r24;
        int n, ev, r;
        reset = 1'b0; clear = 1'b0; white_to_move = 1'b0; eval_valid = 1'b0;
        eval = '0; eval_pv_flag = 1'b0; uci_in = '0; fill_done = 1'b0; rd_req = 1'b0;
        mstate = IDLE; msense = 1'b0; mov = 1'b0; mperr = 1'b0; mrd = 0;
        repeat (2) tick();
        check("reset.rd_valid", rd_valid, 0);
        check("reset.rd_eval", rd_eval, 0);
        check("reset.rd_uci", rd_uci, 0);
        check_status("reset");
        reset = 1'b1;
        tick();

        do_pop();
        check_status("idle_rd_req");

        // Stable sort, white to move, then black to move.
        for (int s = 1; s >= 0; s--) begin
            do_clear(s[0], 1'b0);
            check_status("clear");
            do_push(5, 16'h000A, 1'b0, 1'b0);
            do_push(-3, 16'h000B, 1'b0, 1'b0);
            do_push(40, 16'h000C, 1'b0, 1'b0);
            do_push(5, 16'h000D, 1'b0, 1'b0);
            do_done();
            check_status("basic_filled");
            pop_all("basic");
            do_pop();
            drain("basic_extra");
        end

        // Full list: a worse entry is dropped, a better one evicts the tail.
        do_clear(1'b1, 1'b0);
        for (int k = 1; k <= MAXM; k++) do_push(k, 16'h0100 + k, 1'b0, 1'b0);
        do_push(0, 16'h01F0, 1'b0, 1'b0);
        do_push(99, 16'h01F9, 1'b0, 1'b0);
        check_status("full");
        do_done();
        pop_all("full");

        // Most negative eval with black to move must rank first.
        do_clear(1'b0, 1'b0);
        do_push(3, 16'h0201, 1'b0, 1'b0);
        do_push(-8388608, 16'h0202, 1'b0, 1'b0);
        do_push(-5, 16'h0203, 1'b0, 1'b0);
        do_push(8388607, 16'h0204, 1'b0, 1'b0);
        do_done();
        pop_all("min_eval");

        // PV ordering.
        do_clear(1'b1, 1'b0);
        do_push(100, 16'h0301, 1'b0, 1'b0);
        do_push(7, 16'h0302, 1'b1, 1'b0);
        do_push(200, 16'h0303, 1'b0, 1'b1);
        pop_all("pv");

        // Illegal strobe in READ, empty list, clear beating eval_valid.
        do_clear(1'b1, 1'b0);
        do_push(10, 16'h0401, 1'b0, 1'b0);
        do_done();
        do_push(20, 16'h0402, 1'b0, 1'b0);
        check_status("read_eval");
        do_clear(1'b0, 1'b0);
        do_done();
        check_status("empty_list");
        do_clear(1'b1, 1'b1);
        check_status("clear_eval");

        // Reset mid-READ drops rd_valid without waiting for a clock edge.
        do_push(1, 16'h0501, 1'b0, 1'b0);
        do_push(2, 16'h0502, 1'b0, 1'b1);
        rd_req = 1'b1;
        @(posedge clk);
        rd_req = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_reset.rd_valid", rd_valid, 0);
        mlist.delete(); mstate = IDLE; mov = 1'b0; mperr = 1'b0; mrd = 0;
        check_status("async_reset");
        #1 reset = 1'b1;
        tick();

        // Randomized lists with ties, extremes, PV tags and illegal strobes.
        for (int round = 0; round < 40; round++) begin
            do_clear(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
            n = $urandom_range(0, 11);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 9);
                if (r == 0) do_pop();
                else if (r == 1) tick();
                if ($urandom_range(0, 3) == 0) begin
                    r24 = EVAL_W'($urandom);
                    ev  = int'(r24);
                end else begin
                    ev = int'($urandom_range(0, 8)) - 4;
                end
                do_push(ev, int'($urandom_range(0, 65535)), $urandom_range(0, 9) == 0,
                        (k == n - 1) && ($urandom_range(0, 1) == 1));
            end
            if (mstate == FILL) do_done();
            check_status("rand_filled");
            n = mlist.size() + int'($urandom_range(0, 2));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 7) == 0) do_push(1, 16'h0FFF, 1'b0, 1'b0);
                do_pop();
            end
            drain("rand");
            check_status("rand_end");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
